// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CONVERT, DONE} state_t;

  localparam logic [3:0] ERR_NIBBLE = 4'hE;
  localparam logic [3:0] SAT_NIBBLE = 4'h9;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned max_decimal(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  assign corrected = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one shift-and-correct step per clock.
// Build macro BCD_SATURATE_EN: overflow shows 999999 instead of the EEEEEE error pattern.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(max_decimal(DIGITS));
`ifdef BCD_SATURATE_EN
  localparam logic [3:0] FILL_NIBBLE = SAT_NIBBLE;
`else
  localparam logic [3:0] FILL_NIBBLE = ERR_NIBBLE;
`endif
  localparam logic [BCD_W-1:0] OVF_PATTERN = {DIGITS{FILL_NIBBLE}};

  state_t              state;
  logic [BIN_W-1:0]    operand;
  logic                ovf_cap;
  logic [BIN_W-1:0]    bin_sr;
  logic [BCD_W-1:0]    bcd_sr;
  logic [BCD_W-1:0]    corr;
  logic [ITER_W-1:0]   iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (bcd_sr[4*g +: 4]),
      .corrected (corr[4*g +: 4])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      operand  <= '0;
      ovf_cap  <= 1'b0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= bin_in;
            ovf_cap <= (bin_in > MAX_VAL);
            state   <= LOAD;
          end
        end
        LOAD: begin
          bcd_sr <= '0;
          bin_sr <= operand;
          iter   <= '0;
          busy   <= 1'b1;
          state  <= CONVERT;
        end
        CONVERT: begin
          // Correction feeds the shift in the same cycle; top bit falls off only on overflow.
          {bcd_sr, bin_sr} <= {corr, bin_sr} << 1;
          iter <= iter + 1'b1;
          if (iter == ITER_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          bcd_out  <= ovf_cap ? OVF_PATTERN : bcd_sr;
          overflow <= ovf_cap;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq; expected digits come from decimal arithmetic.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int LAT    = BIN_W + 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              busy;
  logic              done;
  logic [23:0]       bcd_out;
  logic              overflow;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [23:0] prev_bcd = 24'h0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input logic [BIN_W-1:0] v, input int acc);
    exp_t        e;
    int unsigned x;
    x = 32'(v);
    e.acc = acc;
    e.bcd = 24'h0;
    if (x > 999999) begin
      e.ovf = 1'b1;
`ifdef BCD_SATURATE_EN
      e.bcd = 24'h999999;
`else
      e.bcd = 24'hEEEEEE;
`endif
    end else begin
      e.ovf = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        e.bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, and checks bcd_out holds otherwise.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      prev_bcd = 24'h0;
    end else if (done) begin
      done_cnt++;
      check("done_expected", 32'(sbq.size() != 0), 32'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("latency", 32'(cyc - e.acc), 32'(LAT));
        check("busy_at_done", 32'(busy), 32'(0));
      end
      prev_bcd = bcd_out;
    end else begin
      check("bcd_hold", 32'(bcd_out), 32'(prev_bcd));
    end
  end

  // Issue a one-cycle start; the following rising edge accepts it.
  task automatic issue(input logic [BIN_W-1:0] v);
    @(posedge clock);
    #1;
    start  = 1'b1;
    bin_in = v;
    sbq.push_back(model(v, cyc + 1));
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      if (done_cnt >= target) break;
      @(posedge clock);
    end
    check("done_timeout", 32'(done_cnt >= target), 32'(1));
  endtask

  initial begin
    int base;
    int n;
    logic [BIN_W-1:0] v;

    // Reset asserted, then idle
    #1;
    check("rst_bcd", 32'(bcd_out), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (50) @(posedge clock);
    #1;
    check("idle_done_cnt", 32'(done_cnt), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_bcd", 32'(bcd_out), 32'(0));
    check("idle_ovf", 32'(overflow), 32'(0));

    // Directed 123456 with busy window
    base = done_cnt;
    issue(20'd123456);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clock);
      #1;
      check("busy_window", 32'(busy), 32'(k <= LAT - 1));
    end
    wait_done(base + 1);

    // Boundaries and overflow
    base = done_cnt;
    issue(20'd0);       wait_done(base + 1);
    issue(20'd999999);  wait_done(base + 2);
    issue(20'd9);       wait_done(base + 3);
    issue(20'd1000000); wait_done(base + 4);
    issue(20'hFFFFF);   wait_done(base + 5);

    // Start during busy is ignored
    base = done_cnt;
    issue(20'd42);
    repeat (4) @(posedge clock);
    #1;
    start  = 1'b1;
    bin_in = 20'd77;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(base + 1);
    repeat (30) @(posedge clock);
    check("ignored_start_dones", 32'(done_cnt), 32'(base + 1));
    check("ignored_start_bcd", 32'(bcd_out), 32'h000042);

    // Start held high restarts right after done
    base = done_cnt;
    @(posedge clock);
    #1;
    start  = 1'b1;
    bin_in = 20'd271828;
    n = cyc + 1;
    sbq.push_back(model(20'd271828, n));
    @(posedge clock);
    #1;
    bin_in = 20'd161803;
    sbq.push_back(model(20'd161803, n + LAT + 1));
    repeat (LAT + 1) @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(base + 2);
    repeat (30) @(posedge clock);
    check("held_start_dones", 32'(done_cnt), 32'(base + 2));

    // Reset mid-conversion aborts
    base = done_cnt;
    issue(20'd555555);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    void'(sbq.pop_back());
    check("abort_bcd", 32'(bcd_out), 32'(0));
    check("abort_ovf", 32'(overflow), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (30) @(posedge clock);
    check("abort_no_done", 32'(done_cnt), 32'(base));
    issue(20'd314159);
    wait_done(base + 1);

    // Randomized operands, mostly in range with some overflow
    for (int i = 0; i < 25; i++) begin
      base = done_cnt;
      if (i % 4 == 3) v = BIN_W'($urandom_range(1000000, 1048575));
      else            v = BIN_W'($urandom_range(0, 999999));
      issue(v);
      wait_done(base + 1);
    end

    repeat (5) @(posedge clock);
    check("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter: binary value in, six packed BCD digits out.
- Output drives the 24-bit hexval input of the six-digit seven-segment decoder, so the HEX displays show decimal.
- Sits between the Qsys/Avalon register holding the value to display and the seven-segment stage.
- One shift-and-correct step per clock; small area, no divider.

Parameters:
- BIN_W, 20: width of binary input. Must satisfy 2^BIN_W > 10^DIGITS - 1.
- DIGITS, 6: number of BCD digits. Output width is 4*DIGITS.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  in  BIN_W  unsigned binary operand.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when bcd_out/overflow are updated.
- bcd_out  out  4*DIGITS  packed BCD; digit 0 in [3:0]; held between conversions.
- overflow  out  1  high if last accepted operand > 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; bcd_out=0; overflow=0; busy=0; done=0.
  - Iteration counter and shift register cleared.
- States:
  - IDLE -> LOAD when start==1. Operand captured at that edge (call it edge N).
  - LOAD: clear scratch BCD; load operand into shift register; iter=0.
  - CONVERT: each cycle, add 3 to every scratch nibble >= 5, then shift {bcd,bin} left by 1. Stays BIN_W cycles, then -> DONE.
  - DONE: commit result to bcd_out/overflow; done=1 for this cycle only -> IDLE.
- Latency:
  - start accepted at edge N; busy=1 at N+1 .. N+BIN_W+1; done=1 and bcd_out valid at N+BIN_W+2.
  - Default: 22 cycles, start-accept to done.
  - Uniform latency regardless of operand value, including overflow.
- Overflow:
  - Comparison bin_in > 10^DIGITS-1 is made at capture and registered.
  - On overflow, the conversion still runs for full latency. At commit, bcd_out = all nibbles 4'hE (displays "EEEEEE"); overflow=1.
- Handshake:
  - start while busy or in DONE is ignored, not queued.
  - start held high continuously restarts on the first IDLE cycle after done. Back-to-back period = BIN_W+3 cycles.
- bcd_out changes only at commit or reset; never shows intermediate values.
- Reset mid-conversion aborts: no done pulse; outputs go to reset values.
- Arithmetic:
  - Scratch BCD register is 4*DIGITS bits; bits shifted out of the top are discarded. Only reachable on overflow, where the result is overridden anyway.
  - Correction (add 3) precedes shift within the same cycle.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: on overflow, bcd_out = 10^DIGITS-1 in BCD (0x999999); overflow still 1.
- Undefined: error pattern 0xEEEEEE as above.
- Latency, handshake and the overflow flag are identical in both builds.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, LOAD, CONVERT, DONE};
  - ERR_NIBBLE = 4'hE;
  - SAT_NIBBLE = 4'h9;
  - function giving 10^DIGITS-1 for the overflow threshold.
- Sub-module bcd_add3: combinational 4-bit nibble corrector (in >= 5 ? in+3 : in). Instantiated DIGITS times via generate in the datapath.

Test Plan:
- Reset then idle: after reset release, bcd_out=0x000000, overflow=0, busy=0, no done pulse for 50 cycles.
- bin_in=123456, start 1 cycle at edge N -> done exactly at N+22, bcd_out=0x123456, overflow=0; busy high N+1..N+21.
- Boundaries:
  - bin_in=0 -> 0x000000.
  - bin_in=999999 -> 0x999999, overflow=0.
  - bin_in=9 -> 0x000009.
- bin_in=1000000 -> overflow=1 at N+22, bcd_out=0xEEEEEE; with BCD_SATURATE_EN, 0x999999.
- Ignored start: start with bin_in=42, then start with bin_in=77 at N+5 (busy) -> only one done, bcd_out=0x000042; start held high -> second conversion accepted at the IDLE edge after done.
- Reset mid-operation: start 555555, assert reset at N+10 -> outputs cleared immediately, no done. Restart with 314159 -> bcd_out=0x314159 after 22 cycles.
